// File: rtl/riscv_pkg.sv
// Shared integer-core constants and register file types.
package riscv_pkg;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int INFL_W   = 6;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

endpackage : riscv_pkg

// File: rtl/regfile_scoreboard_sb_counter.sv
// Per-register pending-write counter with a "flushed" flag that absorbs
// exactly one writeback arriving after a flush discarded outstanding writes.
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic inc_i,      // an issue targeting this register fired
    input  logic wb_i,       // a writeback targets this register
    input  logic flush_i,
    output logic zero_o,
    output logic one_o,
    output logic max_o,
    output logic flagged_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flag_q, flag_d;
    logic             dec;
    logic             absorb;

    assign zero_o    = (cnt_q == '0);
    assign one_o     = (cnt_q == CNT_ONE);
    assign max_o     = (cnt_q == CNT_MAX);
    assign flagged_o = flag_q;

    // A writeback only decrements when something is outstanding; with nothing
    // outstanding it may instead consume the flushed flag.
    assign dec    = wb_i & ~zero_o;
    assign absorb = wb_i & zero_o & flag_q;

    // Next-state for count and flushed flag; flush dominates issue/writeback.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        cnt_d  = cnt_q;
        flag_d = flag_q & ~absorb;
        if (flush_i) begin
            cnt_d  = '0;
            flag_d = flag_d | ~zero_o;
        end else if (inc_i && !dec && !max_o) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (dec && !inc_i) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_ni) begin
            cnt_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            flag_q <= flag_d;
        end
    end

endmodule : sb_counter

// File: rtl/regfile_scoreboard.sv
// Write-side scoreboard for the integer register file: tracks in-flight
// writes, stalls issue on RAW hazards, bypasses writeback data to issue and
// funnels writebacks onto the register file's single write port.
module regfile_scoreboard
    import riscv_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              issue_valid_i,
    input  reg_addr_t         issue_rs1_addr_i,
    input  reg_addr_t         issue_rs2_addr_i,
    input  logic              issue_use_rs1_i,
    input  logic              issue_use_rs2_i,
    input  reg_addr_t         issue_rd_addr_i,
    input  logic              issue_rd_wren_i,
    output logic              issue_ready_o,
    output logic              fwd_rs1_o,
    output logic              fwd_rs2_o,
    output reg_data_t         fwd_data_o,
    input  logic              wb_valid_i,
    input  reg_addr_t         wb_rd_addr_i,
    input  reg_data_t         wb_data_i,
    output reg_addr_t         rd_addr_o,
    output reg_data_t         rd_data_o,
    output logic              rd_wren_o,
    output logic [INFL_W-1:0] inflight_o,
    output logic              wb_err_o
);

    // Internal total is wide enough for every counter at max, so decrements
    // after a saturated display stay exact.
    localparam int TOT_W = 7;
    localparam logic [TOT_W-1:0] TOT_SAT = TOT_W'((1 << INFL_W) - 1);

    logic [NUM_REGS-1:0] pend_zero;
    logic [NUM_REGS-1:0] pend_one;
    logic [NUM_REGS-1:0] pend_max;
    logic [NUM_REGS-1:0] flagged;

    logic hz1, hz2, byp1, byp2, sat, fire;
    logic wb_live, inc_any, dec_any, err_set;

    logic [TOT_W-1:0] total_q, total_d;
    logic             err_q, err_d;

    // x0 is hard-wired zero: it always looks empty and never flagged.
    assign pend_zero[0] = 1'b1;
    assign pend_one[0]  = 1'b0;
    assign pend_max[0]  = 1'b0;
    assign flagged[0]   = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
        logic inc_r;
        logic wb_r;

        assign inc_r = fire & issue_rd_wren_i & (issue_rd_addr_i == reg_addr_t'(r));
        assign wb_r  = wb_valid_i & (wb_rd_addr_i == reg_addr_t'(r));

        sb_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .inc_i     (inc_r),
            .wb_i      (wb_r),
            .flush_i   (flush_i),
            .zero_o    (pend_zero[r]),
            .one_o     (pend_one[r]),
            .max_o     (pend_max[r]),
            .flagged_o (flagged[r])
        );
    end

    // Register file write port is a zero-latency pass-through; x0 is masked.
    assign wb_live   = wb_valid_i & (wb_rd_addr_i != '0);
    assign rd_wren_o = wb_live;
    assign rd_addr_o = wb_rd_addr_i;
    assign rd_data_o = wb_data_i;

    // Hazard, bypass and issue-acceptance decision.
    always_comb begin
        hz1  = issue_use_rs1_i & (issue_rs1_addr_i != '0) & ~pend_zero[issue_rs1_addr_i];
        hz2  = issue_use_rs2_i & (issue_rs2_addr_i != '0) & ~pend_zero[issue_rs2_addr_i];
        // Forward only when this writeback retires the last outstanding write.
        byp1 = hz1 & wb_valid_i & (wb_rd_addr_i == issue_rs1_addr_i) & pend_one[issue_rs1_addr_i];
        byp2 = hz2 & wb_valid_i & (wb_rd_addr_i == issue_rs2_addr_i) & pend_one[issue_rs2_addr_i];
        // A same-cycle writeback to rd is deliberately ignored here.
        sat  = issue_rd_wren_i & (issue_rd_addr_i != '0) & pend_max[issue_rd_addr_i];
        issue_ready_o = ~flush_i & (~hz1 | byp1) & (~hz2 | byp2) & ~sat;
        fire          = issue_valid_i & issue_ready_o;
    end

    assign fwd_rs1_o  = byp1;
    assign fwd_rs2_o  = byp2;
    assign fwd_data_o = wb_data_i;

    // Running total and sticky underflow flag, mirroring the per-register terms.
    always_comb begin
        inc_any = fire & issue_rd_wren_i & (issue_rd_addr_i != '0) & ~pend_max[issue_rd_addr_i];
        dec_any = wb_live & ~pend_zero[wb_rd_addr_i];
        err_set = wb_live & pend_zero[wb_rd_addr_i] & ~flagged[wb_rd_addr_i];
        err_d   = err_q | err_set;
        total_d = total_q;
        if (flush_i) begin
            total_d = '0;
        end else if (inc_any && !dec_any) begin
            total_d = total_q + TOT_W'(1);
        end else if (dec_any && !inc_any) begin
            total_d = total_q - TOT_W'(1);
        end
    end

    // Total/error state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            total_q <= '0;
            err_q   <= 1'b0;
        end else begin
            total_q <= total_d;
            err_q   <= err_d;
        end
    end

    assign inflight_o = (total_q > TOT_SAT) ? INFL_W'(TOT_SAT) : total_q[INFL_W-1:0];
    assign wb_err_o   = err_q;

endmodule : regfile_scoreboard

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios followed by
// random traffic, all compared against a per-register pending-count model.
module tb_regfile_scoreboard;

    localparam int MAXC = 3;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic        issue_valid_i;
    logic [4:0]  issue_rs1_addr_i, issue_rs2_addr_i, issue_rd_addr_i;
    logic        issue_use_rs1_i, issue_use_rs2_i, issue_rd_wren_i;
    logic        issue_ready_o, fwd_rs1_o, fwd_rs2_o;
    logic [31:0] fwd_data_o;
    logic        wb_valid_i;
    logic [4:0]  wb_rd_addr_i;
    logic [31:0] wb_data_i;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;
    logic        rd_wren_o;
    logic [5:0]  inflight_o;
    logic        wb_err_o;

    int errors = 0;
    int checks = 0;

    int m_pend [32];
    bit m_flag [32];
    bit m_err;

    regfile_scoreboard dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .flush_i          (flush_i),
        .issue_valid_i    (issue_valid_i),
        .issue_rs1_addr_i (issue_rs1_addr_i),
        .issue_rs2_addr_i (issue_rs2_addr_i),
        .issue_use_rs1_i  (issue_use_rs1_i),
        .issue_use_rs2_i  (issue_use_rs2_i),
        .issue_rd_addr_i  (issue_rd_addr_i),
        .issue_rd_wren_i  (issue_rd_wren_i),
        .issue_ready_o    (issue_ready_o),
        .fwd_rs1_o        (fwd_rs1_o),
        .fwd_rs2_o        (fwd_rs2_o),
        .fwd_data_o       (fwd_data_o),
        .wb_valid_i       (wb_valid_i),
        .wb_rd_addr_i     (wb_rd_addr_i),
        .wb_data_i        (wb_data_i),
        .rd_addr_o        (rd_addr_o),
        .rd_data_o        (rd_data_o),
        .rd_wren_o        (rd_wren_o),
        .inflight_o       (inflight_o),
        .wb_err_o         (wb_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < 32; r++) begin
            m_pend[r] = 0;
            m_flag[r] = 1'b0;
        end
        m_err = 1'b0;
    endtask

    function automatic int model_total();
        int s = 0;
        for (int r = 0; r < 32; r++) s += m_pend[r];
        return (s > 63) ? 63 : s;
    endfunction

    task automatic idle();
        flush_i          = 1'b0;
        issue_valid_i    = 1'b0;
        issue_rs1_addr_i = '0;
        issue_rs2_addr_i = '0;
        issue_use_rs1_i  = 1'b0;
        issue_use_rs2_i  = 1'b0;
        issue_rd_addr_i  = '0;
        issue_rd_wren_i  = 1'b0;
        wb_valid_i       = 1'b0;
        wb_rd_addr_i     = '0;
        wb_data_i        = '0;
    endtask

    task automatic issue(input int rs1, input bit u1, input int rs2, input bit u2,
                         input int rd, input bit wr);
        issue_valid_i    = 1'b1;
        issue_rs1_addr_i = 5'(rs1);
        issue_use_rs1_i  = u1;
        issue_rs2_addr_i = 5'(rs2);
        issue_use_rs2_i  = u2;
        issue_rd_addr_i  = 5'(rd);
        issue_rd_wren_i  = wr;
    endtask

    task automatic wb(input int rd, input logic [31:0] data);
        wb_valid_i   = 1'b1;
        wb_rd_addr_i = 5'(rd);
        wb_data_i    = data;
    endtask

    // Inputs are already applied; check combinational outputs, clock one edge,
    // advance the model and check the registered outputs.
    task automatic run_cycle(input string tag);
        bit hz1, hz2, b1, b2, sat, rdy, fire, wbh, dec;
        int a1, a2, rd, wa;
        #1;
        a1 = int'(issue_rs1_addr_i);
        a2 = int'(issue_rs2_addr_i);
        rd = int'(issue_rd_addr_i);
        wa = int'(wb_rd_addr_i);
        hz1 = issue_use_rs1_i && a1 != 0 && m_pend[a1] != 0;
        hz2 = issue_use_rs2_i && a2 != 0 && m_pend[a2] != 0;
        b1  = hz1 && wb_valid_i && wa == a1 && m_pend[a1] == 1;
        b2  = hz2 && wb_valid_i && wa == a2 && m_pend[a2] == 1;
        sat = issue_rd_wren_i && rd != 0 && m_pend[rd] == MAXC;
        rdy = !flush_i && (!hz1 || b1) && (!hz2 || b2) && !sat;
        wbh = wb_valid_i && wa != 0;

        check({tag, ".ready"},    issue_ready_o, rdy);
        check({tag, ".fwd1"},     fwd_rs1_o, b1);
        check({tag, ".fwd2"},     fwd_rs2_o, b2);
        check({tag, ".fwd_data"}, fwd_data_o, wb_data_i);
        check({tag, ".rd_wren"},  rd_wren_o, wbh);
        check({tag, ".rd_addr"},  rd_addr_o, wb_rd_addr_i);
        check({tag, ".rd_data"},  rd_data_o, wb_data_i);

        @(posedge clk_i);
        fire = issue_valid_i && rdy;
        dec  = wbh && m_pend[wa] != 0;
        if (wbh && m_pend[wa] == 0) begin
            if (m_flag[wa]) m_flag[wa] = 1'b0;
            else            m_err      = 1'b1;
        end
        if (flush_i) begin
            for (int r = 1; r < 32; r++) begin
                if (m_pend[r] != 0) m_flag[r] = 1'b1;
                m_pend[r] = 0;
            end
        end else begin
            if (fire && issue_rd_wren_i && rd != 0) m_pend[rd]++;
            if (dec)                                 m_pend[wa]--;
        end
        #1;
        check({tag, ".inflight"}, inflight_o, model_total());
        check({tag, ".wb_err"},   wb_err_o, m_err);
    endtask

    initial begin
        idle();
        model_clear();
        rst_ni = 1'b0;
        #12;
        check("reset.inflight", inflight_o, 0);
        check("reset.wb_err",   wb_err_o, 0);
        check("reset.ready",    issue_ready_o, 1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // First issue: x5 read, x6 written.
        issue(5, 1, 0, 0, 6, 1);
        run_cycle("first");
        check("first.inflight_is1", inflight_o, 1);

        // RAW on x6: stall, then bypass when the only outstanding write returns.
        idle(); issue(6, 1, 0, 0, 0, 0);
        run_cycle("raw_stall0");
        run_cycle("raw_stall1");
        wb(6, 32'hDEADBEEF);
        run_cycle("raw_bypass");

        // Two writes to x7, one retires: still a hazard, no bypass.
        idle(); issue(0, 0, 0, 0, 7, 1);
        run_cycle("x7_a");
        run_cycle("x7_b");
        idle(); wb(7, 32'h1111_2222);
        run_cycle("x7_wb");
        idle(); issue(0, 0, 7, 1, 0, 0);
        run_cycle("x7_stall");
        wb(7, 32'h3333_4444);
        run_cycle("x7_last_bypass");

        // Saturate x3, then try a wb plus new issue to x3 together.
        idle(); issue(0, 0, 0, 0, 3, 1);
        run_cycle("sat1");
        run_cycle("sat2");
        run_cycle("sat3");
        run_cycle("sat4_blocked");
        wb(3, 32'h0000_0033);
        run_cycle("sat_wb_issue");

        // Flush discards pending writes; one late wb is absorbed, a second errors.
        idle(); issue(0, 0, 0, 0, 9, 1);
        run_cycle("x9_issue");
        idle(); flush_i = 1'b1; issue(1, 0, 0, 0, 10, 1);
        run_cycle("flush");
        idle(); wb(9, 32'h9999_0001);
        run_cycle("late_wb1");
        wb(9, 32'h9999_0002);
        run_cycle("late_wb2");

        // x0 never counts, stalls, forwards or errors.
        idle(); issue(0, 1, 0, 1, 0, 1);
        run_cycle("x0_issue");
        idle(); wb(0, 32'hABCD_0000);
        run_cycle("x0_wb");

        // Async reset while stalled on x12.
        idle(); issue(0, 0, 0, 0, 12, 1);
        run_cycle("x12_issue");
        idle(); issue(12, 1, 0, 0, 0, 0);
        #1;
        check("stall12.ready", issue_ready_o, 0);
        #1;
        rst_ni = 1'b0;
        #1;
        model_clear();
        check("async_rst.ready",    issue_ready_o, 1);
        check("async_rst.inflight", inflight_o, 0);
        check("async_rst.wb_err",   wb_err_o, 0);
        idle();
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Random traffic on a small register window to provoke hazards.
        for (int i = 0; i < 600; i++) begin
            idle();
            if ($urandom_range(0, 9) < 7)
                issue($urandom_range(0, 7), 1'($urandom), $urandom_range(0, 7), 1'($urandom),
                      $urandom_range(0, 7), 1'($urandom));
            if ($urandom_range(0, 9) < 4)
                wb($urandom_range(0, 7), $urandom);
            flush_i = ($urandom_range(0, 49) == 0);
            run_cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_regfile_scoreboard
